udp_tx: RTL

//  UDP transmit encapsulator between the user application and the IP TX layer.

---
 rtl/udp_tx_if.sv | 23 ++
 rtl/udp_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/udp_tx_if.sv
// AXI-stream style bundle used on both sides of udp_tx.
//   data  64     beat payload, byte0 at [63:56]
//   user  UserW  side-band word
//   keep  8      byte enables, keep[7] covers [63:56]
//   last  1      last beat of packet
//   valid 1      beat valid
//   ready 1      sink can take the beat
// master drives the beat and samples ready; slave is the mirror image.
interface udp_tx_if #(
  parameter int unsigned UserW = 32
) ();
  logic [63:0]      data;
  logic [UserW-1:0] user;
  logic [7:0]       keep;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, output user, output keep, output last, output valid,
                  input ready);
  modport slave  (input data, input user, input keep, input last, input valid,
                  output ready);
endinterface

// File: rtl/udp_tx.sv
// UDP transmit encapsulator. Prepends one 8-byte UDP header beat
// {src port, dst port, udp length, checksum 0} to a 64-bit payload stream and
// forwards it to the IP layer. Payload is delayed one beat through a hold register.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_dynamic_dst_port   new destination port, loaded when i_dynamic_dst_valid
//   s_axis_user (slave)  payload in; user[15:0] = payload byte length on first beat
//   m_axis_ip (master)   header + payload out; user = {udp_len, 8'h11, 32'h0}.
//                        No backpressure from the IP layer, its ready is ignored.
module udp_tx #(
  parameter logic [15:0] P_SRC_UDP_PORT = 16'h0808,
  parameter logic [15:0] P_DST_UDP_PORT = 16'h0808
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_dynamic_dst_port,
  input  logic        i_dynamic_dst_valid,
  udp_tx_if.slave     s_axis_user,
  udp_tx_if.master    m_axis_ip
);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_keep_q, hold_keep_d;
  logic [15:0] dst_q, dst_d;
  logic [63:0] m_data_q, m_data_d;
  logic [55:0] m_user_q, m_user_d;
  logic [7:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;
  logic        m_valid_q, m_valid_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] udp_len;

  // Upper user bits and the IP-side ready carry no information for this block.
  logic unused_in_user;
  logic unused_ip_ready;
  assign unused_in_user  = ^s_axis_user.user[31:16];
  assign unused_ip_ready = m_axis_ip.ready;

  // Ready is gated by reset so it reads 0 while i_rst is high.
  assign in_ready          = ~i_rst & (state_q != StTail);
  assign s_axis_user.ready = in_ready;
  assign accept            = s_axis_user.valid & in_ready;
  assign udp_len           = s_axis_user.user[15:0] + 16'd8;

  assign m_axis_ip.data  = m_data_q;
  assign m_axis_ip.user  = m_user_q;
  assign m_axis_ip.keep  = m_keep_q;
  assign m_axis_ip.last  = m_last_q;
  assign m_axis_ip.valid = m_valid_q;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    dst_d       = i_dynamic_dst_valid ? i_dynamic_dst_port : dst_q;
    m_data_d    = m_data_q;
    m_user_d    = m_user_q;
    m_keep_d    = 8'hFF;
    m_last_d    = 1'b0;
    m_valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hold_data_d = s_axis_user.data;
          hold_keep_d = s_axis_user.keep;
          // dst_q is the pre-load value, so a same-cycle load hits the next packet.
          m_data_d    = {P_SRC_UDP_PORT, dst_q, udp_len, 16'h0000};
          m_user_d    = {udp_len, 8'h11, 32'h0};
          m_valid_d   = 1'b1;
          state_d     = s_axis_user.last ? StTail : StData;
        end
      end
      StData: begin
        if (accept) begin
          m_data_d    = hold_data_q;
          m_valid_d   = 1'b1;
          hold_data_d = s_axis_user.data;
          hold_keep_d = s_axis_user.keep;
          if (s_axis_user.last) state_d = StTail;
        end
      end
      StTail: begin
        m_data_d  = hold_data_q;
        m_keep_d  = hold_keep_q;
        m_last_d  = 1'b1;
        m_valid_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      dst_q       <= P_DST_UDP_PORT;
      m_data_q    <= '0;
      m_user_q    <= '0;
      m_keep_q    <= 8'hFF;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      dst_q       <= dst_d;
      m_data_q    <= m_data_d;
      m_user_q    <= m_user_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end

endmodule
